demux_sched: RTL and testbench

DEMUX_SCHED -- requirements
Module: demux_sched

---
 rtl/demux_sched_pkg.sv | 22 ++
 rtl/demux_estru.sv | 23 ++
 rtl/demux_sched.sv | 121 ++++++++++++
 tb/tb_demux_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_sched_pkg
//  Description : Shared state encoding and sizing constants for demux_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_sched_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    localparam int N_OUT = 4;
    localparam int SEL_W = 2;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_estru.sv
`default_nettype none
// ============================================================================
//  Module      : demux_estru
//  Description : 1-to-N demux of a single valid bit, Y[S] = D, all others 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_estru
    import demux_sched_pkg::*;
(
    input  logic             D,
    input  logic [SEL_W-1:0] S,
    output logic [N_OUT-1:0] Y
);

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_out
            assign Y[gi] = D & (S == SEL_W'(gi));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/demux_sched.sv
`default_nettype none
// ============================================================================
//  Module      : demux_sched
//  Description : One-deep word holder routing to 4 sinks (round-robin or
//                directed) with stall timeout, drop pulse and drop counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_sched
    import demux_sched_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_dest,
    input  logic              mode,
    input  logic [3:0]        out_ready,
    output logic              in_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        sel,
    output logic              drop,
    output logic [7:0]        drop_cnt
);

    state_t              r_state;
    state_t              w_next_state;
    logic [DATA_W-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic [7:0]          r_stall_cnt;
    logic [7:0]          r_drop_cnt;

    logic                w_hold;
    logic                w_sel_ready;
    logic                w_accept;
    logic                w_transfer;
    logic                w_timeout;
    logic                w_out_valid_int;

    assign w_hold      = (r_state == ST_HOLD);
    assign w_sel_ready = out_ready[r_sel];
    assign w_accept    = in_valid & in_ready;
    assign w_transfer  = w_hold & w_sel_ready;
    // A ready sink in the limit cycle wins: it is a transfer, never a drop.
    assign w_timeout   = w_hold & ~w_sel_ready & (r_stall_cnt == 8'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        in_ready        = 1'b1;
        w_out_valid_int = 1'b0;
        drop            = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                in_ready        = w_sel_ready;
                w_out_valid_int = 1'b1;
                drop            = w_timeout;
                if (w_accept) begin
                    w_next_state = ST_HOLD;
                end else if (w_transfer || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_sel       <= '0;
            r_rr_ptr    <= '0;
            r_stall_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_out_data  <= in_data;
                r_sel       <= mode ? in_dest : r_rr_ptr;
                r_stall_cnt <= '0;
                if (!mode) begin
                    r_rr_ptr <= r_rr_ptr + 2'd1;
                end
            end else if (w_hold && !w_sel_ready && !w_timeout) begin
                r_stall_cnt <= r_stall_cnt + 8'd1;
            end
            if (w_timeout) begin
                r_drop_cnt <= sat_inc8(r_drop_cnt);
            end
        end
    end

    demux_estru u_demux_estru (
        .D (w_out_valid_int),
        .S (r_sel),
        .Y (out_valid)
    );

    assign out_data = r_out_data;
    assign sel      = r_sel;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_sched
//  Description : Self-checking bench for demux_sched: vector table, directed
//                corner sequences and a randomized run against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_sched;

    localparam int DATA_W  = 8;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_dest;
    logic              mode;
    logic [3:0]        out_ready;
    logic              in_ready;
    logic [3:0]        out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        sel;
    logic              drop;
    logic [7:0]        drop_cnt;

    int errors = 0;
    int checks = 0;

    demux_sched #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .mode      (mode),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .sel       (sel),
        .drop      (drop),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] dest;
        logic       md;
        logic [3:0] rdy;
        logic       e_ready;
        logic [3:0] e_valid;
        logic [1:0] e_sel;
        logic [7:0] e_data;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [1:0] dest,
                                input logic md, input logic [3:0] rdy, input logic e_ready,
                                input logic [3:0] e_valid, input logic [1:0] e_sel,
                                input logic [7:0] e_data);
        vec_t r;
        r.v = v; r.d = d; r.dest = dest; r.md = md; r.rdy = rdy;
        r.e_ready = e_ready; r.e_valid = e_valid; r.e_sel = e_sel; r.e_data = e_data;
        return r;
    endfunction

    // Accept a directed word whose sink stays low, then count cycles to the drop.
    task automatic force_drop(input logic [1:0] dest, output int k);
        in_valid  = 1'b1;
        in_data   = 8'h77;
        in_dest   = dest;
        mode      = 1'b1;
        out_ready = ~(4'b0001 << dest);
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (drop) begin
                k = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    // Reference model state
    bit       m_held;
    bit [7:0] m_word;
    bit [1:0] m_sel;
    int       m_rr;
    int       m_stall;
    int       m_dcnt;

    vec_t tbl[14];
    int   k;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_dest = '0; mode = 1'b0; out_ready = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid", out_valid, 4'h0);
        chk("reset_data", out_data, 8'h00);
        chk("reset_sel", sel, 2'd0);
        chk("reset_drop", drop, 1'b0);
        chk("reset_dcnt", drop_cnt, 8'h00);
        chk("reset_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // RR sweep, directed word, rr continuity, then backpressure
        tbl[0]  = mk(1, 8'hA1, 2'd0, 0, 4'hF, 1, 4'b0001, 2'd0, 8'hA1);
        tbl[1]  = mk(1, 8'hA2, 2'd0, 0, 4'hF, 1, 4'b0010, 2'd1, 8'hA2);
        tbl[2]  = mk(1, 8'hA3, 2'd0, 0, 4'hF, 1, 4'b0100, 2'd2, 8'hA3);
        tbl[3]  = mk(1, 8'hA4, 2'd0, 0, 4'hF, 1, 4'b1000, 2'd3, 8'hA4);
        tbl[4]  = mk(0, 8'h00, 2'd0, 0, 4'hF, 1, 4'b0000, 2'd3, 8'hA4);
        tbl[5]  = mk(1, 8'h5C, 2'd2, 1, 4'hF, 1, 4'b0100, 2'd2, 8'h5C);
        tbl[6]  = mk(0, 8'h00, 2'd0, 0, 4'hF, 1, 4'b0000, 2'd2, 8'h5C);
        tbl[7]  = mk(1, 8'h11, 2'd3, 0, 4'hF, 1, 4'b0001, 2'd0, 8'h11);
        tbl[8]  = mk(1, 8'h22, 2'd3, 0, 4'hF, 1, 4'b0010, 2'd1, 8'h22);
        tbl[9]  = mk(1, 8'h33, 2'd0, 0, 4'b1101, 0, 4'b0010, 2'd1, 8'h22);
        tbl[10] = mk(1, 8'h33, 2'd0, 0, 4'b1101, 0, 4'b0010, 2'd1, 8'h22);
        tbl[11] = mk(1, 8'h33, 2'd0, 0, 4'b1101, 0, 4'b0010, 2'd1, 8'h22);
        tbl[12] = mk(1, 8'h33, 2'd0, 0, 4'b0010, 1, 4'b0100, 2'd2, 8'h33);
        tbl[13] = mk(0, 8'h00, 2'd0, 0, 4'hF, 1, 4'b0000, 2'd2, 8'h33);

        for (int i = 0; i < 14; i++) begin
            in_valid = tbl[i].v; in_data = tbl[i].d; in_dest = tbl[i].dest;
            mode = tbl[i].md; out_ready = tbl[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d_in_ready", i), in_ready, tbl[i].e_ready);
            chk($sformatf("vec%0d_drop", i), drop, 1'b0);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_valid", i), out_valid, tbl[i].e_valid);
            chk($sformatf("vec%0d_sel", i), sel, tbl[i].e_sel);
            chk($sformatf("vec%0d_data", i), out_data, tbl[i].e_data);
        end
        chk("dcnt_after_table", drop_cnt, 8'h00);

        // Timeout: drop on the 16th cycle after accept, i.e. 15 after the first HOLD cycle
        force_drop(2'd3, k);
        chk("timeout_cycle", k, 16);
        chk("timeout_valid", out_valid, 4'h0);
        chk("timeout_dcnt", drop_cnt, 8'd1);
        chk("timeout_ready", in_ready, 1'b1);

        // Saturation
        for (int i = 0; i < 256; i++) begin
            force_drop(2'(i), k);
            if (i == 0 || i == 253 || i == 254 || i == 255) begin
                chk($sformatf("sat_dcnt_%0d", i), drop_cnt, (i + 2 > 255) ? 255 : i + 2);
                chk($sformatf("sat_cycle_%0d", i), k, 16);
            end
        end

        // Reset while holding a word for sink 1
        in_valid = 1'b1; in_data = 8'h3E; in_dest = 2'd1; mode = 1'b1; out_ready = 4'b1101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rsthold_valid_pre", out_valid, 4'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("rsthold_valid", out_valid, 4'h0);
        chk("rsthold_data", out_data, 8'h00);
        chk("rsthold_sel", sel, 2'd0);
        chk("rsthold_drop", drop, 1'b0);
        chk("rsthold_dcnt", drop_cnt, 8'h00);
        @(posedge clk); #2;
        chk("rsthold_valid_edge", out_valid, 4'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = 8'h99; mode = 1'b0; out_ready = 4'hF;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 4'b0001);
        chk("post_rst_sel", sel, 2'd0);
        chk("post_rst_data", out_data, 8'h99);
        chk("post_rst_dcnt", drop_cnt, 8'h00);

        // Randomized run against the reference model
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        m_held = 0; m_word = 0; m_sel = 0; m_rr = 0; m_stall = 0; m_dcnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit       e_ready;
            bit       e_drop;
            bit       acc;
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'($urandom);
            in_dest  = 2'($urandom);
            mode     = 1'($urandom);
            if (((cyc / 40) % 3) == 2)
                out_ready = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'h0;
            else
                out_ready = 4'($urandom);
            @(negedge clk);
            e_ready = !m_held || out_ready[m_sel];
            e_drop  = m_held && !out_ready[m_sel] && (m_stall == TIMEOUT);
            chk("rnd_in_ready", in_ready, e_ready);
            chk("rnd_drop", drop, e_drop);
            acc = in_valid && e_ready;
            if (acc) begin
                m_held  = 1;
                m_word  = in_data;
                m_sel   = mode ? in_dest : 2'(m_rr);
                m_stall = 0;
                if (!mode) m_rr = (m_rr + 1) % 4;
            end else if (m_held && out_ready[m_sel]) begin
                m_held = 0;
            end else if (e_drop) begin
                m_held = 0;
                m_dcnt = (m_dcnt < 255) ? m_dcnt + 1 : 255;
            end else if (m_held) begin
                m_stall++;
            end
            @(posedge clk); #1;
            chk("rnd_valid", out_valid, m_held ? (4'b0001 << m_sel) : 4'h0);
            chk("rnd_dcnt", drop_cnt, m_dcnt);
            if (m_held) begin
                chk("rnd_sel", sel, m_sel);
                chk("rnd_data", out_data, m_word);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
